// File: rtl/dds_param_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dds_param_scheduler
// Description : Timed parameter scheduler for a DDS core. Update requests
//               {time, freq, phase, sync} are queued in a 4-entry FIFO and
//               applied strictly in arrival order when the free-running
//               timestamp reaches each entry's time. Applying an entry
//               loads the active frequency/phase (and optionally the time
//               offset) and raises a one-cycle apply strobe.
//
// Ports       :
//   clk          in   1   system clock
//   resetn       in   1   synchronous active-low reset
//   s_valid      in   1   update request valid
//   s_ready      out  1   request accepted when s_valid && s_ready
//   s_time       in   48  timestamp at which the update takes effect
//   s_freq       in   48  new frequency word
//   s_phase      in   14  new phase word
//   s_sync       in   1   1 = reload time_offset with s_time at apply
//   timestamp    out  48  free-running time counter
//   freq         out  48  active frequency word
//   phase        out  14  active phase word
//   time_offset  out  48  active time offset
//   apply_pulse  out  1   one-cycle strobe per applied update
//   fifo_count   out  3   queued entries, 0..4
//   late_error   out  1   sticky late-update flag
//
// Build option: define DDS_SCHED_LATE_DETECT_EN to enable late-entry
//               detection. When undefined, late_error is tied low and a
//               head whose time has already passed waits for the 48-bit
//               timestamp wrap.
//
// Revision    : 1.0  initial release
// ============================================================================

module dds_param_scheduler (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [47:0] s_time,
    input  logic [47:0] s_freq,
    input  logic [13:0] s_phase,
    input  logic        s_sync,
    output logic [47:0] timestamp,
    output logic [47:0] freq,
    output logic [13:0] phase,
    output logic [47:0] time_offset,
    output logic        apply_pulse,
    output logic [2:0]  fifo_count,
    output logic        late_error
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0]  c_DEPTH    = 3'd4;
    localparam logic [47:0] c_HALF_SPAN = 48'h8000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // FIFO empty
        ST_WAIT  = 2'd1,   // head present, waiting for its time
        ST_APPLY = 2'd2    // head was applied on entry to this state
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [47:0] r_ts;
    logic [47:0] r_freq;
    logic [13:0] r_phase;
    logic [47:0] r_toff;
    logic        r_apply;

    logic [2:0]  r_count;
    logic [1:0]  r_rd_ptr;
    logic [1:0]  r_wr_ptr;
    logic [3:0]  r_armed;

    logic [47:0] r_mem_time  [4];
    logic [47:0] r_mem_freq  [4];
    logic [13:0] r_mem_phase [4];
    logic        r_mem_sync  [4];

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic        w_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_fire;
    logic        w_head_valid;
    logic        w_hit;
    logic        w_head_armed;
    logic [47:0] w_head_time;
    logic [47:0] w_head_freq;
    logic [13:0] w_head_phase;
    logic        w_head_sync;
    logic [1:0]  w_slot_off [4];
    logic [3:0]  w_slot_valid;

    // Ready depends only on the registered count, never on s_valid.
    assign w_ready      = (r_count < c_DEPTH);
    assign w_push       = s_valid && w_ready;

    assign w_head_valid = (r_count != 3'd0);
    assign w_head_time  = r_mem_time[r_rd_ptr];
    assign w_head_freq  = r_mem_freq[r_rd_ptr];
    assign w_head_phase = r_mem_phase[r_rd_ptr];
    assign w_head_sync  = r_mem_sync[r_rd_ptr];
    assign w_hit        = (w_head_time == r_ts);
    assign w_head_armed = r_armed[r_rd_ptr];

    // A queued entry whose time goes by while it is still behind another
    // entry (or while the FSM sits in APPLY) would otherwise miss its exact
    // match and wait a full wrap. Each slot therefore latches an "armed" bit
    // when the timestamp equals its time while the entry is queued, so
    // entries with equal or adjacent times apply back to back. Entries that
    // were already in the past when pushed never arm.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_slot_off[i]   = 2'(i) - r_rd_ptr;
            w_slot_valid[i] = ({1'b0, w_slot_off[i]} < r_count);
        end
    end

`ifdef DDS_SCHED_LATE_DETECT_EN
    // Late detection is evaluated only on the first WAIT cycle of each head.
    logic r_first_wait;
    logic r_late_error;
    logic w_behind;
    logic w_late;

    // Head time lies in the past half of the modular time span.
    assign w_behind   = ((w_head_time - r_ts) >= c_HALF_SPAN);
    assign w_late     = r_first_wait && w_behind && !w_head_armed;
    assign w_fire     = w_head_valid && (w_hit || w_head_armed || w_late);
    assign late_error = r_late_error;
`else
    assign w_fire     = w_head_valid && (w_hit || w_head_armed);
    assign late_error = 1'b0;
`endif

    // The head is popped on the same edge that loads the active parameters.
    assign w_pop = (r_state == ST_WAIT) && w_fire;

    // ------------------------------------------------------------------------
    // Free-running timestamp (wraps naturally at 2^48)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ts <= 48'd0;
        end else begin
            r_ts <= r_ts + 48'd1;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage (contents are don't-care while not counted as valid)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_time[r_wr_ptr]  <= s_time;
            r_mem_freq[r_wr_ptr]  <= s_freq;
            r_mem_phase[r_wr_ptr] <= s_phase;
            r_mem_sync[r_wr_ptr]  <= s_sync;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers, occupancy and per-slot armed bits
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count  <= 3'd0;
            r_rd_ptr <= 2'd0;
            r_wr_ptr <= 2'd0;
            r_armed  <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end

            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase

            for (int i = 0; i < 4; i++) begin
                if (w_push && (r_wr_ptr == 2'(i))) begin
                    r_armed[i] <= 1'b0;
                end else if (w_slot_valid[i] && (r_mem_time[i] == r_ts)) begin
                    r_armed[i] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scheduler FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_freq  <= 48'd0;
            r_phase <= 14'd0;
            r_toff  <= 48'd0;
            r_apply <= 1'b0;
`ifdef DDS_SCHED_LATE_DETECT_EN
            r_first_wait <= 1'b0;
            r_late_error <= 1'b0;
`endif
        end else begin
            r_apply <= 1'b0;
`ifdef DDS_SCHED_LATE_DETECT_EN
            r_first_wait <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    // Leave IDLE on the edge where the FIFO becomes non-empty.
                    if (w_head_valid || w_push) begin
                        r_state <= ST_WAIT;
`ifdef DDS_SCHED_LATE_DETECT_EN
                        r_first_wait <= 1'b1;
`endif
                    end
                end

                ST_WAIT: begin
                    if (w_fire) begin
                        // Parameters become visible in the cycle after the
                        // match, i.e. together with the APPLY state.
                        r_state <= ST_APPLY;
                        r_freq  <= w_head_freq;
                        r_phase <= w_head_phase;
                        r_apply <= 1'b1;
                        if (w_head_sync) begin
                            r_toff <= w_head_time;
                        end
`ifdef DDS_SCHED_LATE_DETECT_EN
                        if (w_late) begin
                            r_late_error <= 1'b1;
                        end
`endif
                    end
                end

                ST_APPLY: begin
                    // r_count already reflects the pop; a push arriving on
                    // this edge also counts as a remaining entry.
                    if (w_head_valid || w_push) begin
                        r_state <= ST_WAIT;
`ifdef DDS_SCHED_LATE_DETECT_EN
                        r_first_wait <= 1'b1;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign s_ready     = w_ready;
    assign timestamp   = r_ts;
    assign freq        = r_freq;
    assign phase       = r_phase;
    assign time_offset = r_toff;
    assign apply_pulse = r_apply;
    assign fifo_count  = r_count;

endmodule

`default_nettype wire
